// File: rtl/service_2_timer_run_pkg.sv
// -----------------------------------------------------------------------------
// service_pkg
// Shared types and constants for the mm:ss countdown timer run stage.
//   state_t      : run-stage FSM states
//   time_t       : 16-bit BCD mm:ss value, nibbles M10 M1 S10 S1
//   BCD_MAX_*    : largest legal digit for units/minutes digits and seconds-tens
//   clamp_time() : forces every nibble of a loaded value into its legal range
// -----------------------------------------------------------------------------
package service_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef logic [15:0] time_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  // Seconds-tens saturates at 5, every other digit at 9.
  function automatic time_t clamp_time(input time_t t);
    time_t r;
    r[15:12] = (t[15:12] > BCD_MAX_UNITS) ? BCD_MAX_UNITS : t[15:12];
    r[11:8]  = (t[11:8]  > BCD_MAX_UNITS) ? BCD_MAX_UNITS : t[11:8];
    r[7:4]   = (t[7:4]   > BCD_MAX_TENS)  ? BCD_MAX_TENS  : t[7:4];
    r[3:0]   = (t[3:0]   > BCD_MAX_UNITS) ? BCD_MAX_UNITS : t[3:0];
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// -----------------------------------------------------------------------------
// bcd_mmss_dec
// Combinational one-second decrement of a BCD mm:ss value, done digit by digit
// with borrows (S1 9..0 -> S10 5..0 -> M1 9..0 -> M10 9..0), never through a
// binary intermediate.
// Ports:
//   value  : BCD mm:ss input
//   result : value minus one second (0000 wraps to 9959)
//   zero   : result is 0000
// -----------------------------------------------------------------------------
module bcd_mmss_dec
  import service_pkg::*;
(
  input  time_t value,
  output time_t result,
  output logic  zero
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    result = value;
    if (value[3:0] != 4'd0) begin
      result[3:0] = value[3:0] - 4'd1;
    end else begin
      result[3:0] = BCD_MAX_UNITS;
      if (value[7:4] != 4'd0) begin
        result[7:4] = value[7:4] - 4'd1;
      end else begin
        result[7:4] = BCD_MAX_TENS;
        if (value[11:8] != 4'd0) begin
          result[11:8] = value[11:8] - 4'd1;
        end else begin
          result[11:8]  = BCD_MAX_UNITS;
          result[15:12] = (value[15:12] != 4'd0) ? value[15:12] - 4'd1 : BCD_MAX_UNITS;
        end
      end
    end
  end

  assign zero = (result == 16'h0000);

endmodule

// File: rtl/service_2_timer_run.sv
// -----------------------------------------------------------------------------
// service_2_timer_run
// Run stage of an mm:ss countdown timer. Holds the remaining time in BCD,
// counts it down once per CLK_HZ cycles while running, pulses done on expiry.
// Optional feature macro: TIMER_BLINK_EN (blinks the display in EXPIRED).
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   load       : one-cycle pulse, loads time_in (digits clamped) and goes IDLE
//   time_in    : BCD mm:ss from the time-set stage
//   start_stop : one-cycle button pulse, start / pause / resume / acknowledge
//   num        : remaining time, BCD mm:ss
//   running    : high while in RUN
//   done       : one-cycle pulse in the cycle num reaches 0000
//   sel        : digit enable mask for the display stage
// -----------------------------------------------------------------------------
module service_2_timer_run
  import service_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic        start_stop,
  output logic [15:0] num,
  output logic        running,
  output logic        done,
  output logic [3:0]  sel
);

  localparam int             PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);

  state_t        state, state_next;
  time_t         num_next;
  logic [PW-1:0] presc, presc_next;
  logic          done_next;
  time_t         dec_num;
  logic          dec_zero;

  bcd_mmss_dec u_dec (
    .value  (num),
    .result (dec_num),
    .zero   (dec_zero)
  );

  // A RUN cycle carrying start_stop already counts as paused: the prescaler
  // freezes on the button cycle, so a pause/resume pair loses no time.
  always_comb begin
    state_next = state;
    num_next   = num;
    presc_next = presc;
    done_next  = 1'b0;
    if (load) begin
      num_next   = clamp_time(time_in);
      presc_next = '0;
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_stop && (num != 16'h0000)) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (start_stop) begin
            state_next = ST_PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_next = '0;
            num_next   = dec_num;
            if (dec_zero) begin
              state_next = ST_EXPIRED;
              done_next  = 1'b1;
            end
          end else begin
            presc_next = presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_next = ST_RUN;
        end
        ST_EXPIRED: begin
          if (start_stop) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state   <= ST_IDLE;
      num     <= 16'h0000;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      num     <= num_next;
      presc   <= presc_next;
      running <= (state_next == ST_RUN);
      done    <= done_next;
    end
  end

`ifdef TIMER_BLINK_EN
  localparam int            HALF      = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int            BW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic [3:0]    sel_q;

  // Blank on entry to EXPIRED, then toggle every HALF cycles while there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q     <= 4'b1111;
      blink_cnt <= '0;
    end else if (state_next == ST_EXPIRED) begin
      if (state != ST_EXPIRED) begin
        sel_q     <= 4'b0000;
        blink_cnt <= '0;
      end else if (blink_cnt == HALF_LAST) begin
        sel_q     <= ~sel_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      sel_q     <= 4'b1111;
      blink_cnt <= '0;
    end
  end

  assign sel = sel_q;
`else
  assign sel = 4'b1111;
`endif

endmodule

// File: tb/tb_service_2_timer_run.sv
// -----------------------------------------------------------------------------
// tb_service_2_timer_run
// Directed bench for service_2_timer_run at CLK_HZ=4. A seconds-based model
// tracks remaining time as an integer and is compared with the DUT on every
// falling edge; hand-computed literals pin the model at key points.
// -----------------------------------------------------------------------------
module tb_service_2_timer_run;

  localparam int CLK_HZ = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic        start_stop = 1'b0;
  logic [15:0] num;
  logic        running;
  logic        done;
  logic [3:0]  sel;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  service_2_timer_run #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .time_in    (time_in),
    .start_stop (start_stop),
    .num        (num),
    .running    (running),
    .done       (done),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: remaining time as plain seconds ----------------
  typedef struct {
    int   secs;
    int   cnt;
    int   mode;
    int   exp_cnt;
    logic done;
  } model_t;

  model_t mdl;

  function automatic int digit_min(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic int clamp_secs(input logic [15:0] t);
    int m10, m1, s10, s1;
    m10 = digit_min(int'(t[15:12]), 9);
    m1  = digit_min(int'(t[11:8]), 9);
    s10 = digit_min(int'(t[7:4]), 5);
    s1  = digit_min(int'(t[3:0]), 9);
    return (m10 * 10 + m1) * 60 + s10 * 10 + s1;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, c;
    m = s / 60;
    c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic model_t model_next(input model_t m, input logic rst, input logic ld,
                                        input logic [15:0] t, input logic ss);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (!rst) begin
      n.secs = 0; n.cnt = 0; n.mode = M_IDLE; n.exp_cnt = 0;
    end else if (ld) begin
      n.secs = clamp_secs(t); n.cnt = 0; n.mode = M_IDLE;
    end else begin
      case (m.mode)
        M_IDLE:  if (ss && m.secs != 0) n.mode = M_RUN;
        M_RUN: begin
          if (ss) n.mode = M_PAUSE;
          else begin
            // one second elapses after CLK_HZ running cycles
            n.cnt = m.cnt + 1;
            if (n.cnt == CLK_HZ) begin
              n.cnt  = 0;
              n.secs = m.secs - 1;
              if (n.secs == 0) begin
                n.mode = M_EXP;
                n.done = 1'b1;
              end
            end
          end
        end
        M_PAUSE: if (ss) n.mode = M_RUN;
        default: if (ss) n.mode = M_IDLE;
      endcase
    end
    if (n.mode == M_EXP) n.exp_cnt = (m.mode == M_EXP) ? m.exp_cnt + 1 : 0;
    return n;
  endfunction

  function automatic logic [3:0] model_sel(input model_t m);
`ifdef TIMER_BLINK_EN
    if (m.mode == M_EXP) return (((m.exp_cnt / (CLK_HZ / 2)) % 2) == 0) ? 4'b0000 : 4'b1111;
`endif
    return 4'b1111;
  endfunction

  always @(posedge clk) mdl <= model_next(mdl, reset, load, time_in, start_stop);

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_num", num, to_bcd(mdl.secs));
      check("cmp_running", 16'(running), 16'(mdl.mode == M_RUN));
      check("cmp_done", 16'(done), 16'(mdl.done));
      check("cmp_sel", 16'(sel), 16'(model_sel(mdl)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ld, input logic [15:0] t, input logic ss);
    @(negedge clk);
    load = ld;
    time_in = t;
    start_stop = ss;
    @(posedge clk);
    #1;
    load = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    int  n;
    bit  seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset_num", num, 16'h0000);
    check("reset_running", 16'(running), 16'h0);
    check("reset_done", 16'(done), 16'h0);
    check("reset_sel", 16'(sel), 16'h000F);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;

    // full countdown from 00:12
    step(1'b1, 16'h0012, 1'b0);
    check("load_0012", num, 16'h0012);
    step(1'b0, 16'h0000, 1'b1);
    check("start_running", 16'(running), 16'h1);
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    check("expiry_seen", 16'(seen), 16'h1);
    check("expiry_cycles", 16'(n), 16'd48);
    check("expiry_num", num, 16'h0000);
    check("expiry_running", 16'(running), 16'h0);
`ifdef TIMER_BLINK_EN
    check("blink_sel0", 16'(sel), 16'h0000);
`endif
    @(posedge clk);
    #1;
    check("done_one_cycle", 16'(done), 16'h0);
`ifdef TIMER_BLINK_EN
    check("blink_sel1", 16'(sel), 16'h0000);
    @(posedge clk);
    #1;
    check("blink_sel2", 16'(sel), 16'h000F);
    @(posedge clk);
    #1;
    check("blink_sel3", 16'(sel), 16'h000F);
`endif
    step(1'b0, 16'h0000, 1'b1);
    check("ack_num", num, 16'h0000);
    check("ack_sel", 16'(sel), 16'h000F);

    // minute and ten-minute borrows
    step(1'b1, 16'h0100, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(4);
    check("borrow_0100", num, 16'h0059);
    step(1'b1, 16'h1000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(4);
    check("borrow_1000", num, 16'h0959);

    // load clamping and zero start
    step(1'b1, 16'h0075, 1'b0);
    check("clamp_0075", num, 16'h0055);
    step(1'b1, 16'hAB7C, 1'b0);
    check("clamp_AB7C", num, 16'h9959);
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    check("zero_start_running", 16'(running), 16'h0);

    // pause at prescaler 2, resume
    step(1'b1, 16'h0030, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(2);
    step(1'b0, 16'h0000, 1'b1);
    check("pause_running", 16'(running), 16'h0);
    idle(20);
    check("pause_hold", num, 16'h0030);
    step(1'b0, 16'h0000, 1'b1);
    check("resume_running", 16'(running), 16'h1);
    idle(1);
    check("resume_plus1", num, 16'h0030);
    idle(1);
    check("resume_plus2", num, 16'h0029);

    // load beats start_stop while running
    step(1'b1, 16'h0123, 1'b1);
    check("load_wins_num", num, 16'h0123);
    check("load_wins_running", 16'(running), 16'h0);

    // reset mid-run
    step(1'b0, 16'h0000, 1'b1);
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_run_num", num, 16'h0000);
    check("rst_run_running", 16'(running), 16'h0);
    check("rst_run_done", 16'(done), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(10);
    check("post_rst_done", 16'(done), 16'h0);
    step(1'b0, 16'h0000, 1'b1);
    check("post_rst_idle", 16'(running), 16'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/service_2_timer_run.md
SERVICE_2_TIMER_RUN -- requirements
Module: service_2_timer_run

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clock cycles per 1 s tick (minimum 2).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port load, input, 1, one-cycle pulse from the time-set stage's finish output.
REQ-005 SHALL have port time_in, input, 16, BCD mm:ss from the time-set stage, nibbles [15:12][11:8][7:4][3:0] = M10 M1 S10 S1.
REQ-006 SHALL have port start_stop, input, 1, one-cycle debounced button pulse.
REQ-007 SHALL have port num, output, 16, current remaining time, BCD, same nibble layout.
REQ-008 SHALL have port running, output, 1, high while in RUN.
REQ-009 SHALL have port done, output, 1, one-cycle pulse on expiry.
REQ-010 SHALL have port sel, output, 4, digit enable mask for the display stage.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, PAUSE, EXPIRED, all registered.
REQ-012 load in any state SHALL register num <= time_in, clear the prescaler and enter IDLE next cycle.
REQ-013 On load, an S10 nibble >5 SHALL be clamped to 5; any other nibble >9 SHALL be clamped to 9.
REQ-014 load and start_stop in the same cycle: load SHALL win and start_stop SHALL be ignored.
REQ-015 IDLE + start_stop with num != 0000 SHALL go to RUN; with num == 0000, start_stop SHALL be ignored.
REQ-016 RUN + start_stop SHALL go to PAUSE; PAUSE + start_stop SHALL go to RUN.
REQ-017 The prescaler SHALL count only in RUN and hold its value in PAUSE.
REQ-018 The prescaler SHALL wrap 0..CLK_HZ-1 and assert tick in the cycle it equals CLK_HZ-1.
REQ-019 A tick in RUN SHALL decrement num by one second, with the update visible the next cycle.
REQ-020 BCD decrement: S1 9..0, borrows into S10 5..0, borrows into M1 9..0, borrows into M10 9..0; no binary intermediate.
REQ-021 When a decrement yields 0000, FSM SHALL enter EXPIRED in the same cycle num becomes 0000.
REQ-022 done SHALL pulse high for exactly that one cycle.
REQ-023 EXPIRED + start_stop SHALL go to IDLE with num held at 0000.
REQ-024 running SHALL equal (state == RUN) as a registered output.
REQ-025 sel SHALL be 4'b1111 in IDLE, RUN and PAUSE.

Reset
REQ-026 When reset is low at a rising edge: num=0000, state=IDLE, prescaler=0, running=0, done=0, sel=4'b1111.
REQ-027 Reset mid-RUN SHALL abort the countdown with no done pulse.

Configuration
REQ-028 Macro TIMER_BLINK_EN defined: in EXPIRED, sel SHALL toggle between 4'b1111 and 4'b0000 every CLK_HZ/2 cycles, starting at 4'b0000 on entry.
REQ-029 Macro TIMER_BLINK_EN undefined: sel SHALL stay 4'b1111 in EXPIRED and the blink counter SHALL not exist.

Structure
REQ-030 Package service_pkg SHALL hold the state enum, the BCD limit constants (9, 5) and the 16-bit time type.
REQ-031 Sub-module bcd_mmss_dec (combinational: 16-bit in, 16-bit out, zero flag) SHALL implement REQ-020.

Verification (CLK_HZ=4)
REQ-032 load time_in=0012, start_stop -> running=1; after 12 ticks (48 cycles) num=0000, done for 1 cycle, EXPIRED.
REQ-033 num=0100 with one tick -> num=0059; num=1000 with one tick -> num=0959.
REQ-034 time_in=0075 loaded -> num=0055; time_in=0000 then start_stop -> state stays IDLE, running=0.
REQ-035 RUN at 0030, start_stop at prescaler=2, wait 20 cycles, start_stop -> num still 0030; next decrement 2 cycles later.
REQ-036 load and start_stop in the same cycle during RUN -> num=time_in, IDLE, running=0; reset low mid-RUN -> num=0000, done never pulses.
REQ-037 With TIMER_BLINK_EN: after expiry sel=0000 for 2 cycles, then 1111 for 2 cycles; start_stop -> sel=1111, IDLE.
